cm0_pmu_cdc_recv_hs: RTL and testbench
======================================

// Module: cm0_pmu_cdc_recv_hs
// PURPOSE
//  Receive end of the PMU 4-phase req/ack CDC handshake. Inputs REQASYNC and DATAASYNC are
//  driven from CDC-safe send registers in a foreign clock domain. The block synchronises
//  REQASYNC and captures the bundled data once. It then presents the data locally with a
//  valid/ready handshake and returns ACKOUT from a glitch-free register.
// PARAMETERS
//  SYNC_STAGES  2    synchroniser depth on REQASYNC; legal range 2..4
//  DW           8    width of the bundled data word
//  TO_CYCLES    1024 ACK_WAIT cycle count that flags TIMEOUT (used only with the macro)
// PORTS
//  REGCLK     in   1   local clock; only clock in the block
//  REGRST     in   1   reset: synchronous, active-high
//  REQASYNC   in   1   request level from the remote send register; asynchronous to REGCLK
//  DATAASYNC  in   DW  bundled data; remote holds it stable from before req rise until ack seen
//  DATAREADY  in   1   local consumer can accept DATAOUT
//  DATAVALID  out  1   DATAOUT holds a captured word
//  DATAOUT    out  DW  captured data word
//  ACKOUT     out  1   acknowledge to the remote domain; driven directly from a flop
//  TIMEOUT    out  1   sticky flag: remote did not drop req in time
// BEHAVIOUR
//  Reset (REGRST=1 at a REGCLK edge):
//   - state=IDLE; all outputs 0 (DATAVALID, DATAOUT, ACKOUT, TIMEOUT).
//   - Synchroniser flops=0; timeout counter=0.
//  Synchroniser: REQS = REQASYNC delayed SYNC_STAGES flops. Nothing else samples REQASYNC.
//  FSM, one flop set, states IDLE, VALID, ACK_WAIT:
//   IDLE:
//    - On REQS=1: capture DATAASYNC into DATAOUT, set DATAVALID=1, go to VALID.
//    - This is level-triggered. A REQ still high after reset is treated as a new request.
//   VALID:
//    - Transfer happens when DATAVALID & DATAREADY.
//    - On transfer: DATAVALID<=0, ACKOUT<=1, go to ACK_WAIT.
//    - DATAOUT stays stable until the transfer; it is never recaptured in VALID or ACK_WAIT.
//   ACK_WAIT:
//    - On REQS=0: ACKOUT<=0, go to IDLE.
//    - The next request is accepted no earlier than the cycle after IDLE is re-entered.
//  Latency:
//   - REQASYNC rise to DATAVALID=1 is SYNC_STAGES+1 edges.
//   - Transfer to ACKOUT=1 is 1 edge.
//   - REQS fall to ACKOUT=0 is 1 edge.
//  ACKOUT changes only on an FSM transition. It must not glitch in any other cycle.
//  DATAAS YNC is sampled only on the IDLE->VALID edge; it is never synchronised bit-wise.
//  Boundary conditions:
//   - REQS drops while in VALID (protocol violation): stay in VALID, still complete the local
//     transfer, then go through ACK_WAIT. ACK_WAIT sees REQS=0 and returns to IDLE in 1 cycle.
//   - DATAREADY held high: the word transfers in its first VALID cycle. DATAVALID is high for
//     exactly 1 cycle.
//   - Reset mid-handshake: all state clears; the remote side must tolerate ACKOUT dropping.
// CONFIGURATION
//  Macro CM0_PMU_CDC_RECV_TIMEOUT_EN.
//  Defined:
//   - A ceil(log2(TO_CYCLES+1))-bit counter clears on ACK_WAIT entry and increments each
//     ACK_WAIT cycle.
//   - When the count reaches TO_CYCLES, TIMEOUT<=1. TIMEOUT is sticky until REGRST.
//   - The FSM is unaffected and keeps waiting.
//  Not defined: no counter is built; TIMEOUT is tied 0.
// STRUCTURE
//  Shared include cm0_pmu_cdc_defs.v holds:
//   - State encodings CM0_PMU_CDC_ST_IDLE/VALID/ACK_WAIT (2-bit).
//   - Default SYNC_STAGES.
//  Sub-module cm0_pmu_cdc_sync:
//   - Parameterised SYNC_STAGES-deep flop chain with REGCLK/REGRST, one bit.
//   - Reused for every PMU receive crossing.
// TESTING
//  1. Basic: REQASYNC=1, DATAASYNC=8'hA5, DATAREADY=1 -> DATAVALID=1 with DATAOUT=A5 at edge 3
//     (SYNC_STAGES=2); ACKOUT=1 at edge 4. Drop REQASYNC -> ACKOUT=0 after 3 edges; back in IDLE.
//  2. Backpressure: DATAREADY=0 for 10 cycles, with DATAASYNC changed to 8'h3C after capture ->
//     DATAOUT holds A5 and DATAVALID=1 throughout, ACKOUT stays 0; READY=1 -> ACKOUT=1 next edge.
//  3. Reset mid-op: REGRST=1 for 1 cycle while in ACK_WAIT, REQASYNC still 1 -> all outputs 0;
//     the block then recaptures as a new request (DATAVALID=1 at edge 3 after reset release).
//  4. Back-to-back: 4 handshakes with 8'h00,8'hFF,8'h55,8'hAA -> 4 DATAVALID pulses in order;
//     no duplicates; ACKOUT toggles exactly 8 times.
//  5. Timeout (macro on, TO_CYCLES=16): hold REQASYNC=1 after ack -> TIMEOUT=1 after 16
//     ACK_WAIT cycles and stays 1; macro off -> TIMEOUT stays 0.
//  6. Glitch check: random DATAREADY/REQASYNC timing -> ACKOUT changes only on FSM
//     transitions; assertion REQS !== X after reset.

Source files
------------

// File: rtl/cm0_pmu_cdc_recv_hs_pkg.sv
// Shared definitions for the PMU req/ack CDC receive path: FSM state encodings and default sync depth.
package cm0_pmu_cdc_recv_hs_pkg;

    localparam int CM0_PMU_CDC_SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        CM0_PMU_CDC_ST_IDLE     = 2'b00,
        CM0_PMU_CDC_ST_VALID    = 2'b01,
        CM0_PMU_CDC_ST_ACK_WAIT = 2'b10
    } cm0_pmu_cdc_state_t;

endpackage

// File: rtl/cm0_pmu_cdc_sync.sv
// Single-bit SYNC_STAGES-deep synchroniser flop chain, shared by every PMU receive crossing.
module cm0_pmu_cdc_sync
    import cm0_pmu_cdc_recv_hs_pkg::*;
#(
    parameter int SYNC_STAGES = CM0_PMU_CDC_SYNC_STAGES_DEF
) (
    input  logic REGCLK,
    input  logic REGRST,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    // Bit 0 is the metastability-catching flop; the top bit is safe to use locally.
    always_ff @(posedge REGCLK) begin
        if (REGRST) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/cm0_pmu_cdc_recv_hs.sv
// Receive end of the PMU 4-phase req/ack handshake; SYNC_STAGES legal range 2..4.
// Optional ACK_WAIT timeout flag is built only when CM0_PMU_CDC_RECV_TIMEOUT_EN is defined.
module cm0_pmu_cdc_recv_hs
    import cm0_pmu_cdc_recv_hs_pkg::*;
#(
    parameter int SYNC_STAGES = CM0_PMU_CDC_SYNC_STAGES_DEF,
    parameter int DW          = 8,
    parameter int TO_CYCLES   = 1024
) (
    input  logic          REGCLK,
    input  logic          REGRST,
    input  logic          REQASYNC,
    input  logic [DW-1:0] DATAASYNC,
    input  logic          DATAREADY,
    output logic          DATAVALID,
    output logic [DW-1:0] DATAOUT,
    output logic          ACKOUT,
    output logic          TIMEOUT
);

    cm0_pmu_cdc_state_t state;
    cm0_pmu_cdc_state_t state_nxt;
    logic               reqs;
    logic               capture;
    logic               transfer;
    logic               valid_nxt;
    logic               ack_nxt;

    cm0_pmu_cdc_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_req_sync (
        .REGCLK (REGCLK),
        .REGRST (REGRST),
        .d      (REQASYNC),
        .q      (reqs)
    );

    always_ff @(posedge REGCLK) begin
        if (REGRST) begin
            state <= CM0_PMU_CDC_ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A request in VALID that drops early still has to finish locally before ACK_WAIT.
    always_comb begin
        state_nxt = state;
        case (state)
            CM0_PMU_CDC_ST_IDLE:     if (reqs)      state_nxt = CM0_PMU_CDC_ST_VALID;
            CM0_PMU_CDC_ST_VALID:    if (transfer)  state_nxt = CM0_PMU_CDC_ST_ACK_WAIT;
            CM0_PMU_CDC_ST_ACK_WAIT: if (!reqs)     state_nxt = CM0_PMU_CDC_ST_IDLE;
            default:                                state_nxt = CM0_PMU_CDC_ST_IDLE;
        endcase
    end

    always_comb begin
        capture   = 1'b0;
        transfer  = 1'b0;
        valid_nxt = DATAVALID;
        ack_nxt   = ACKOUT;
        case (state)
            CM0_PMU_CDC_ST_IDLE: begin
                if (reqs) begin
                    capture   = 1'b1;
                    valid_nxt = 1'b1;
                end
            end
            CM0_PMU_CDC_ST_VALID: begin
                if (DATAVALID && DATAREADY) begin
                    transfer  = 1'b1;
                    valid_nxt = 1'b0;
                    ack_nxt   = 1'b1;
                end
            end
            CM0_PMU_CDC_ST_ACK_WAIT: begin
                if (!reqs) begin
                    ack_nxt = 1'b0;
                end
            end
            default: begin
                valid_nxt = 1'b0;
                ack_nxt   = 1'b0;
            end
        endcase
    end

    // ACKOUT and the data word are registered so the remote side only ever sees clean edges.
    always_ff @(posedge REGCLK) begin
        if (REGRST) begin
            DATAVALID <= 1'b0;
            DATAOUT   <= '0;
            ACKOUT    <= 1'b0;
        end else begin
            DATAVALID <= valid_nxt;
            ACKOUT    <= ack_nxt;
            if (capture) begin
                DATAOUT <= DATAASYNC;
            end
        end
    end

`ifdef CM0_PMU_CDC_RECV_TIMEOUT_EN
    localparam int CW = $clog2(TO_CYCLES + 1);

    logic [CW-1:0] to_cnt;
    logic [CW-1:0] to_cnt_inc;

    assign to_cnt_inc = to_cnt + CW'(1);

    // Count saturates at TO_CYCLES; the flag stays set until reset even after req drops.
    always_ff @(posedge REGCLK) begin
        if (REGRST) begin
            to_cnt  <= '0;
            TIMEOUT <= 1'b0;
        end else begin
            if (transfer) begin
                to_cnt <= '0;
            end else if (state == CM0_PMU_CDC_ST_ACK_WAIT && to_cnt != CW'(TO_CYCLES)) begin
                to_cnt <= to_cnt_inc;
            end
            if (state == CM0_PMU_CDC_ST_ACK_WAIT && to_cnt_inc == CW'(TO_CYCLES)) begin
                TIMEOUT <= 1'b1;
            end
        end
    end
`else
    // No counter in this build; TO_CYCLES is still referenced so both builds share one parameter list.
    assign TIMEOUT = (TO_CYCLES < 0);
`endif

endmodule

// File: tb/tb_cm0_pmu_cdc_recv_hs.sv
// Self-checking bench for cm0_pmu_cdc_recv_hs: handshake-level reference model plus directed literal checks.
module tb_cm0_pmu_cdc_recv_hs;

    localparam int SS = 2;
    localparam int TO = 16;

    logic       REGCLK;
    logic       REGRST;
    logic       REQASYNC;
    logic [7:0] DATAASYNC;
    logic       DATAREADY;
    logic       DATAVALID;
    logic [7:0] DATAOUT;
    logic       ACKOUT;
    logic       TIMEOUT;

    int errors = 0;
    int checks = 0;
    bit checking = 0;

    cm0_pmu_cdc_recv_hs #(
        .SYNC_STAGES (SS),
        .DW          (8),
        .TO_CYCLES   (TO)
    ) dut (
        .REGCLK    (REGCLK),
        .REGRST    (REGRST),
        .REQASYNC  (REQASYNC),
        .DATAASYNC (DATAASYNC),
        .DATAREADY (DATAREADY),
        .DATAVALID (DATAVALID),
        .DATAOUT   (DATAOUT),
        .ACKOUT    (ACKOUT),
        .TIMEOUT   (TIMEOUT)
    );

    initial begin
        REGCLK = 1'b0;
        forever #5 REGCLK = ~REGCLK;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=running exp=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge REGCLK);
    endtask

    // Reference model: the request seen locally is REQASYNC SS edges ago; a word is
    // either waiting for the consumer, or acknowledged and waiting for the request to drop.
    bit         reqHist[SS];
    bit         mValid;
    bit         mAck;
    bit         mTimeout;
    logic [7:0] mOut = 8'h00;
    int         toCnt;
    bit         seenReq;

    always @(posedge REGCLK) begin
        if (REGRST) begin
            for (int i = 0; i < SS; i++) reqHist[i] = 1'b0;
            mValid   = 1'b0;
            mAck     = 1'b0;
            mTimeout = 1'b0;
            mOut     = 8'h00;
            toCnt    = 0;
        end else begin
            seenReq = reqHist[SS-1];
            if (mValid) begin
                if (DATAREADY) begin
                    mValid = 1'b0;
                    mAck   = 1'b1;
                    toCnt  = 0;
                end
            end else if (mAck) begin
                toCnt++;
`ifdef CM0_PMU_CDC_RECV_TIMEOUT_EN
                if (toCnt == TO) mTimeout = 1'b1;
`endif
                if (!seenReq) mAck = 1'b0;
            end else if (seenReq) begin
                mValid = 1'b1;
                mOut   = DATAASYNC;
            end
            for (int i = SS - 1; i > 0; i--) reqHist[i] = reqHist[i-1];
            reqHist[0] = REQASYNC;
        end
    end

    always @(negedge REGCLK) begin
        if (checking) begin
            checkOutput("model_valid", DATAVALID, mValid);
            checkOutput("model_ack", ACKOUT, mAck);
            checkOutput("model_data", DATAOUT, mOut);
            checkOutput("model_timeout", TIMEOUT, mTimeout);
            checkOutput("reqs_known", $isunknown(dut.reqs), 0);
        end
    end

    // Transfer log and ACKOUT edge counter for the back-to-back sequence.
    bit         logOn = 0;
    int         ackToggles = 0;
    logic       ackPrev = 1'b0;
    logic [7:0] xferLog[$];

    always @(negedge REGCLK) begin
        if (logOn) begin
            if (ACKOUT !== ackPrev) ackToggles++;
            if (DATAVALID === 1'b1 && DATAREADY === 1'b1) xferLog.push_back(DATAOUT);
        end
        ackPrev = ACKOUT;
    end

    task automatic waitAck(input logic val, input string name);
        int n = 0;
        while (ACKOUT !== val && n < 30) begin
            @(negedge REGCLK);
            n++;
        end
        checkOutput(name, ACKOUT, val);
    endtask

    task automatic applyStimulus(input logic [7:0] word);
        DATAASYNC = word;
        REQASYNC  = 1'b1;
        waitAck(1'b1, "hs_ack_rise");
        REQASYNC  = 1'b0;
        waitAck(1'b0, "hs_ack_fall");
    endtask

    logic [7:0] expWords[4] = '{8'h00, 8'hFF, 8'h55, 8'hAA};
    logic       expTo;

    initial begin
`ifdef CM0_PMU_CDC_RECV_TIMEOUT_EN
        expTo = 1'b1;
`else
        expTo = 1'b0;
`endif
        REGRST    = 1'b1;
        REQASYNC  = 1'b0;
        DATAASYNC = 8'h00;
        DATAREADY = 1'b0;
        tick(1);
        checkOutput("rst_valid", DATAVALID, 0);
        checkOutput("rst_data", DATAOUT, 0);
        checkOutput("rst_ack", ACKOUT, 0);
        checkOutput("rst_timeout", TIMEOUT, 0);
        checking = 1'b1;
        tick(1);
        REGRST = 1'b0;
        tick(2);

        $display("[TB] basic handshake");
        REQASYNC = 1'b1; DATAASYNC = 8'hA5; DATAREADY = 1'b1;
        tick(2);
        checkOutput("basic_valid_edge2", DATAVALID, 0);
        tick(1);
        checkOutput("basic_valid_edge3", DATAVALID, 1);
        checkOutput("basic_data_edge3", DATAOUT, 8'hA5);
        checkOutput("basic_ack_edge3", ACKOUT, 0);
        tick(1);
        checkOutput("basic_ack_edge4", ACKOUT, 1);
        checkOutput("basic_valid_edge4", DATAVALID, 0);
        REQASYNC = 1'b0;
        tick(2);
        checkOutput("basic_ack_hold", ACKOUT, 1);
        tick(1);
        checkOutput("basic_ack_drop", ACKOUT, 0);
        tick(3);

        $display("[TB] backpressure");
        DATAREADY = 1'b0; REQASYNC = 1'b1; DATAASYNC = 8'hA5;
        tick(3);
        checkOutput("bp_valid", DATAVALID, 1);
        DATAASYNC = 8'h3C;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            checkOutput("bp_hold_valid", DATAVALID, 1);
            checkOutput("bp_hold_data", DATAOUT, 8'hA5);
            checkOutput("bp_hold_ack", ACKOUT, 0);
        end
        DATAREADY = 1'b1;
        tick(1);
        checkOutput("bp_ack", ACKOUT, 1);
        REQASYNC = 1'b0;
        tick(3);
        checkOutput("bp_ack_drop", ACKOUT, 0);
        tick(2);

        $display("[TB] req drops while valid");
        DATAREADY = 1'b0; REQASYNC = 1'b1; DATAASYNC = 8'hE7;
        tick(3);
        REQASYNC = 1'b0;
        tick(4);
        checkOutput("viol_valid", DATAVALID, 1);
        checkOutput("viol_data", DATAOUT, 8'hE7);
        DATAREADY = 1'b1;
        tick(1);
        checkOutput("viol_ack", ACKOUT, 1);
        tick(1);
        checkOutput("viol_ack_drop", ACKOUT, 0);
        tick(2);

        $display("[TB] reset mid-handshake");
        REQASYNC = 1'b1; DATAASYNC = 8'h5A;
        tick(4);
        checkOutput("mid_ack", ACKOUT, 1);
        REGRST = 1'b1;
        tick(1);
        checkOutput("mid_rst_valid", DATAVALID, 0);
        checkOutput("mid_rst_data", DATAOUT, 0);
        checkOutput("mid_rst_ack", ACKOUT, 0);
        checkOutput("mid_rst_timeout", TIMEOUT, 0);
        REGRST = 1'b0; DATAASYNC = 8'hC3;
        tick(2);
        checkOutput("mid_valid_edge2", DATAVALID, 0);
        tick(1);
        checkOutput("mid_valid_edge3", DATAVALID, 1);
        checkOutput("mid_data_edge3", DATAOUT, 8'hC3);
        tick(1);
        checkOutput("mid_ack2", ACKOUT, 1);
        REQASYNC = 1'b0;
        tick(3);
        checkOutput("mid_ack2_drop", ACKOUT, 0);
        tick(2);

        $display("[TB] back-to-back");
        DATAREADY = 1'b1;
        xferLog.delete();
        ackToggles = 0;
        logOn = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(expWords[i]);
        tick(2);
        logOn = 1'b0;
        checkOutput("b2b_count", xferLog.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < xferLog.size()) checkOutput("b2b_word", xferLog[i], expWords[i]);
            else checkOutput("b2b_word_missing", 32'hFFFF_FFFF, expWords[i]);
        end
        checkOutput("b2b_ack_toggles", ackToggles, 8);

        $display("[TB] timeout");
        REQASYNC = 1'b1; DATAASYNC = 8'h77;
        tick(4);
        checkOutput("to_ack", ACKOUT, 1);
        tick(15);
        checkOutput("to_before", TIMEOUT, 0);
        tick(1);
        checkOutput("to_at", TIMEOUT, expTo);
        REQASYNC = 1'b0;
        tick(3);
        checkOutput("to_ack_drop", ACKOUT, 0);
        tick(2);
        checkOutput("to_sticky", TIMEOUT, expTo);

        $display("[TB] random timing");
        for (int i = 0; i < 300; i++) begin
            tick(1);
            DATAREADY = 1'($urandom_range(0, 1));
            if (!REQASYNC && !ACKOUT && $urandom_range(0, 3) == 0) begin
                DATAASYNC = 8'($urandom);
                REQASYNC  = 1'b1;
            end else if (REQASYNC && ACKOUT && $urandom_range(0, 2) == 0) begin
                REQASYNC = 1'b0;
            end
        end
        REQASYNC = 1'b0;
        DATAREADY = 1'b1;
        tick(4);
        waitAck(1'b0, "rand_settle");

        REGRST = 1'b1;
        tick(1);
        REGRST = 1'b0;
        checkOutput("final_rst_valid", DATAVALID, 0);
        checkOutput("final_rst_ack", ACKOUT, 0);
        checkOutput("final_rst_timeout", TIMEOUT, 0);
        tick(2);
        checking = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
